// File: rtl/sub_pipe.sv
// Two-stage pipelined subtractor (diff = a - b) split at the half-word boundary,
// with valid/ready handshakes on both sides and borrow/overflow/zero flags.
module sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);
    localparam int HALF = WIDTH / 2;

    typedef struct packed {
        logic [HALF-1:0] lo_diff;
        logic            c_half;
        logic [HALF-1:0] a_hi;
        logic [HALF-1:0] b_hi;
    } s1_t;

    logic             r_s1_valid;
    s1_t              r_s1;
    s1_t              w_s1_nxt;
    logic             w_s2_load;
    logic [HALF-1:0]  w_hi_diff;
    logic             w_c_out;
    logic [WIDTH-1:0] w_diff;
    logic             w_overflow;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;

    // Low half: a + ~b + 1; the carry out feeds the high half next cycle.
    always_comb begin
        w_s1_nxt = '0;
        {w_s1_nxt.c_half, w_s1_nxt.lo_diff} =
            {1'b0, a[HALF-1:0]} + {1'b0, ~b[HALF-1:0]} + (HALF+1)'(1);
        w_s1_nxt.a_hi = a[WIDTH-1:HALF];
        w_s1_nxt.b_hi = b[WIDTH-1:HALF];
    end

    assign {w_c_out, w_hi_diff} =
        {1'b0, r_s1.a_hi} + {1'b0, ~r_s1.b_hi} + {{HALF{1'b0}}, r_s1.c_half};
    assign w_diff     = {w_hi_diff, r_s1.lo_diff};
    assign w_overflow = (r_s1.a_hi[HALF-1] != r_s1.b_hi[HALF-1]) &
                        (w_hi_diff[HALF-1] != r_s1.a_hi[HALF-1]);

    // Output register may load unless it holds an unconsumed result.
    assign w_s2_load = ~(r_out_valid & ~out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1 <= w_s1_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff     <= w_diff;
                r_borrow   <= ~w_c_out;
                r_overflow <= w_overflow;
                r_zero     <= (w_diff == '0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
endmodule

// File: tb/tb_sub_pipe.sv
// Directed and streaming checks for sub_pipe: reset, flag corner cases,
// backpressure hold, back-to-back throughput and mid-stream reset.
module tb_sub_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow, overflow, zero;

    int total = 0;
    int bad   = 0;

    sub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference: full-width 33-bit subtraction, independent of the half split.
    function automatic logic [W+2:0] golden(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        t = {1'b0, x} - {1'b0, y};
        return {t[W-1:0], t[W], (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]), t[W-1:0] == '0};
    endfunction

    // One cycle: drive at negedge, sample shortly after, then pass the rising edge.
    task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ordy, output logic acc, output logic ovh,
                       output logic ir, output logic ov_v, output logic [W+2:0] res);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; out_ready = ordy;
        #2;
        ir   = in_ready;
        ov_v = out_valid;
        acc  = iv & in_ready;
        ovh  = out_valid & ordy;
        res  = {diff, borrow, overflow, zero};
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        total++;
        if ({in_ready, out_valid, diff, borrow, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
            bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h flags=%b%b%b, expected 1 0 0 000",
                     in_ready, out_valid, diff, borrow, overflow, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single operation through an empty pipe; the result appears two edges after presentation.
    task automatic test_vec(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
        logic acc, ovh, ir, ovv;
        logic [W+2:0] res;
        cyc(1'b1, ta, tb, 1'b1, acc, ovh, ir, ovv, res);
        total++;
        if (!acc || ovv !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: in_ready=%b out_valid=%b, expected 1 0", name, ir, ovv);
        end
        cyc(1'b0, '0, '0, 1'b1, acc, ovh, ir, ovv, res);
        total++;
        if (ovv !== 1'b0) begin
            bad++;
            $display("FAIL %s early: out_valid=%b, expected 0", name, ovv);
        end
        cyc(1'b0, '0, '0, 1'b1, acc, ovh, ir, ovv, res);
        total++;
        if (ovv !== 1'b1 || res !== {ed, eb, eo, ez}) begin
            bad++;
            $display("FAIL %s result: valid=%b diff=%h b/o/z=%b%b%b, expected 1 %h %b%b%b",
                     name, ovv, res[W+2:3], res[2], res[1], res[0], ed, eb, eo, ez);
        end
        cyc(1'b0, '0, '0, 1'b1, acc, ovh, ir, ovv, res);
        total++;
        if (ovv !== 1'b0) begin
            bad++;
            $display("FAIL %s dup: out_valid=%b, expected 0", name, ovv);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] oa [4];
        logic [W-1:0] ob [4];
        logic [W+2:0] q[$];
        logic [W+2:0] res, e, held;
        logic acc, ovh, ir, ovv;
        int k, got;
        oa[0] = 32'h0000_0010; ob[0] = 32'h0000_0001;
        oa[1] = 32'h0000_0000; ob[1] = 32'h0000_0005;
        oa[2] = 32'hAAAA_0000; ob[2] = 32'h5555_0001;
        oa[3] = 32'h8000_0000; ob[3] = 32'h7FFF_FFFF;
        k = 0; got = 0;
        held = golden(oa[0], ob[0]);
        for (int i = 0; i < 6; i++) begin
            if (k < 2) cyc(1'b1, oa[k], ob[k], 1'b0, acc, ovh, ir, ovv, res);
            else       cyc(1'b1, $urandom, $urandom, 1'b0, acc, ovh, ir, ovv, res);
            if (acc) begin q.push_back(golden(oa[k], ob[k])); k++; end
            if (i >= 2) begin
                total++;
                if (ir !== 1'b0 || ovv !== 1'b1 || res !== held) begin
                    bad++;
                    $display("FAIL bp_hold cyc%0d: in_ready=%b valid=%b res=%h, expected 0 1 %h",
                             i, ir, ovv, res, held);
                end
            end
        end
        total++;
        if (k != 2) begin
            bad++;
            $display("FAIL bp_accepted: %0d operands accepted, expected 2", k);
        end
        for (int i = 0; i < 12 && !(got == 4 && k == 4); i++) begin
            if (k < 4) cyc(1'b1, oa[k], ob[k], 1'b1, acc, ovh, ir, ovv, res);
            else       cyc(1'b0, '0, '0, 1'b1, acc, ovh, ir, ovv, res);
            if (ovh) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: unexpected result %h, expected none", res);
                end else begin
                    e = q.pop_front();
                    if (res !== e) begin
                        bad++;
                        $display("FAIL bp_order #%0d: got %h, expected %h", got, res, e);
                    end
                end
                got++;
            end
            if (acc) begin q.push_back(golden(oa[k], ob[k])); k++; end
        end
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL bp_drain: %0d results, expected 4", got);
        end
        cyc(1'b0, '0, '0, 1'b1, acc, ovh, ir, ovv, res);
        total++;
        if (ovv !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: out_valid=%b, expected 0", ovv);
        end
    endtask

    task automatic test_back_to_back;
        logic [W+2:0] q[$];
        logic [W+2:0] res, e;
        logic [W-1:0] ra, rb;
        logic acc, ovh, ir, ovv, iv;
        int sent, got, last;
        sent = 0; got = 0; last = -1;
        for (int i = 0; i < 130 && got < 100; i++) begin
            ra = $urandom; rb = $urandom;
            iv = (sent < 100);
            cyc(iv, ra, rb, 1'b1, acc, ovh, ir, ovv, res);
            if (iv) begin
                total++;
                if (ir !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready cyc%0d: in_ready=%b, expected 1", i, ir);
                end
            end
            if (ovh) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra cyc%0d: result %h, expected none", i, res);
                end else begin
                    e = q.pop_front();
                    if (res !== e) begin
                        bad++;
                        $display("FAIL b2b_data #%0d: got %h, expected %h", got, res, e);
                    end
                end
                if (last >= 0) begin
                    total++;
                    if (i != last + 1) begin
                        bad++;
                        $display("FAIL b2b_bubble: result at cycle %0d, expected %0d", i, last + 1);
                    end
                end
                last = i;
                got++;
            end
            if (acc) begin q.push_back(golden(ra, rb)); sent++; end
        end
        total++;
        if (got != 100) begin
            bad++;
            $display("FAIL b2b_count: %0d results, expected 100", got);
        end
    endtask

    task automatic test_reset_midstream;
        logic acc, ovh, ir, ovv;
        logic [W+2:0] res;
        cyc(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, acc, ovh, ir, ovv, res);
        cyc(1'b1, 32'h0000_0200, 32'h0000_0002, 1'b0, acc, ovh, ir, ovv, res);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: out_valid=%b, expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, diff, borrow, overflow, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
            bad++;
            $display("FAIL rstmid: in_ready=%b out_valid=%b diff=%h flags=%b%b%b, expected 1 0 0 000",
                     in_ready, out_valid, diff, borrow, overflow, zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_vec("post_reset", 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_vec("basic",      32'd5,        32'd3,        32'd2,        1'b0, 1'b0, 1'b0);
        test_vec("underflow",  32'd0,        32'd1,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        test_vec("zero",       32'h1234_5678, 32'h1234_5678, 32'd0,        1'b0, 1'b0, 1'b1);
        test_vec("cross_half", 32'h0001_0000, 32'd1,        32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        test_vec("ovf_neg",    32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        test_vec("ovf_pos",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        test_backpressure;
        test_back_to_back;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
